// File: rtl/pattern_loader_pkg.sv
// Shared types and constants for the filter pattern loader.
// Contents: FSM state encoding, control-register map constants, word-to-address helper.
// No ports; imported by the loader top.
package pattern_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIS_WR,
    PAT_WR,
    PAT_RD,
    PAT_WAIT,
    EN_WR,
    FIN
  } state_t;

  // Control-register slave map
  localparam int CTRL_ADDR     = 0;  // bit 0 = wrken
  localparam int PAT_BASE_ADDR = 1;  // pattern words live at PAT_BASE_ADDR .. PAT_BASE_ADDR+PAT_WIDTH-1

  localparam int CTRL_ENABLE  = 1;
  localparam int CTRL_DISABLE = 0;

  // Pattern word index k is 1-based; word k lives at PAT_BASE_ADDR + k - 1.
  function automatic int pat_addr(input int k);
    return PAT_BASE_ADDR + k - 1;
  endfunction

endpackage

// File: rtl/pattern_loader_if.sv
// Avalon-MM bundle between the pattern loader (master) and the control-register slave.
// Signals: address/write/writedata/read from master; waitrequest/readdata/readdatavalid from slave.
// Suffixes are from the master's point of view.
interface pattern_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int REG_WIDTH  = 32
);

  logic [ADDR_WIDTH-1:0] amm_address_o;
  logic                  amm_write_o;
  logic [REG_WIDTH-1:0]  amm_writedata_o;
  logic                  amm_read_o;
  logic                  amm_waitrequest_i;
  logic [REG_WIDTH-1:0]  amm_readdata_i;
  logic                  amm_readdatavalid_i;

  modport master (
    output amm_address_o,
    output amm_write_o,
    output amm_writedata_o,
    output amm_read_o,
    input  amm_waitrequest_i,
    input  amm_readdata_i,
    input  amm_readdatavalid_i
  );

  modport slave (
    input  amm_address_o,
    input  amm_write_o,
    input  amm_writedata_o,
    input  amm_read_o,
    output amm_waitrequest_i,
    output amm_readdata_i,
    output amm_readdatavalid_i
  );

endinterface

// File: rtl/pattern_loader_amm_cmd_master.sv
// Holds one registered Avalon-MM read or write command on the bus until the slave accepts it.
// Latency: a command loaded at edge E is on the bus in the following cycle; strobes come straight from flops.
// Backpressure: while waitrequest is high the command is held unchanged; accept_o reports the accepting cycle.
// Ports: clk_i/srst_i; load_* (new command from FSM); accept_o, rdv_o, rdata_o (status to FSM); amm (bus).
module amm_cmd_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  load_i,
  input  logic                  load_rd_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [REG_WIDTH-1:0]  load_data_i,
  output logic                  accept_o,
  output logic                  rdv_o,
  output logic [REG_WIDTH-1:0]  rdata_o,
  pattern_loader_if.master      amm
);

  logic                  write_q, write_d;
  logic                  read_q,  read_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [REG_WIDTH-1:0]  data_q,  data_d;

  assign accept_o = (write_q | read_q) & ~amm.amm_waitrequest_i;
  assign rdv_o    = amm.amm_readdatavalid_i;
  assign rdata_o  = amm.amm_readdata_i;

  // A load may coincide with acceptance of the previous command, which lets
  // back-to-back commands occupy consecutive cycles.
  always_comb begin
    write_d = write_q;
    read_d  = read_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      write_d = ~load_rd_i;
      read_d  = load_rd_i;
      addr_d  = load_addr_i;
      data_d  = load_rd_i ? '0 : load_data_i;
    end else if (accept_o) begin
      write_d = 1'b0;
      read_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign amm.amm_write_o     = write_q;
  assign amm.amm_read_o      = read_q;
  assign amm.amm_address_o   = addr_q;
  assign amm.amm_writedata_o = data_q;

endmodule

// File: rtl/pattern_loader.sv
// Sequencer that disables the filter, writes the pattern words, reads them back, then optionally re-enables.
// Latency: first command on the bus the cycle after an accepted start; zero-wait run ends with done_o 12 cycles later.
// Backpressure: stalls on waitrequest without advancing; waits up to TIMEOUT cycles per read for readdatavalid.
// Ports: clk_i/srst_i; start_i, pattern_i, enable_after_i (request); busy_o, done_o, err_o, err_addr_o (status); amm (bus).
module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PAT_WIDTH  = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  start_i,
  input  logic [REG_WIDTH-1:0]  pattern_i [PAT_WIDTH],
  input  logic                  enable_after_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  pattern_loader_if.master      amm
);

  localparam int KW = $clog2(PAT_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;        // current word index, 1-based
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [REG_WIDTH-1:0]  pat_q [PAT_WIDTH];
  logic [REG_WIDTH-1:0]  pat_d [PAT_WIDTH];
  logic                  en_after_q, en_after_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic                  ld;
  logic                  ld_rd;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [REG_WIDTH-1:0]  ld_data;
  logic                  acc;
  logic                  rdv;
  logic [REG_WIDTH-1:0]  rdata;

  logic                  last;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign last      = (k_q == KW'(PAT_WIDTH));
  assign cur_addr  = ADDR_WIDTH'(pat_addr(int'(k_q)));
  assign next_addr = ADDR_WIDTH'(pat_addr(int'(k_q) + 1));

  amm_cmd_master #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_WIDTH  (REG_WIDTH)
  ) u_cmd (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .load_i      (ld),
    .load_rd_i   (ld_rd),
    .load_addr_i (ld_addr),
    .load_data_i (ld_data),
    .accept_o    (acc),
    .rdv_o       (rdv),
    .rdata_o     (rdata),
    .amm         (amm)
  );

  // Each state names the command currently on the bus; the next command is
  // loaded in the same cycle the current one is accepted.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    tmr_d      = tmr_q;
    pat_d      = pat_q;
    en_after_d = en_after_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    ld         = 1'b0;
    ld_rd      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          pat_d      = pattern_i;
          en_after_d = enable_after_i;
          err_d      = 1'b0;
          err_addr_d = '0;
          k_d        = '0;
          ld         = 1'b1;
          ld_addr    = ADDR_WIDTH'(CTRL_ADDR);
          ld_data    = REG_WIDTH'(CTRL_DISABLE);
          state_d    = DIS_WR;
        end
      end

      DIS_WR: begin
        if (acc) begin
          k_d     = KW'(1);
          ld      = 1'b1;
          ld_addr = ADDR_WIDTH'(pat_addr(1));
          ld_data = pat_q[0];
          state_d = PAT_WR;
        end
      end

      PAT_WR: begin
        if (acc) begin
          ld = 1'b1;
          if (last) begin
            k_d     = KW'(1);
            ld_rd   = 1'b1;
            ld_addr = ADDR_WIDTH'(pat_addr(1));
            state_d = PAT_RD;
          end else begin
            k_d     = k_q + 1'b1;
            ld_addr = next_addr;
            ld_data = pat_q[k_q];   // word k+1 is element k
          end
        end
      end

      PAT_RD: begin
        if (acc) begin
          tmr_d   = TW'(TIMEOUT);
          state_d = PAT_WAIT;
        end
      end

      PAT_WAIT: begin
        tmr_d = tmr_q - 1'b1;
        if (rdv) begin
          if (rdata == pat_q[k_q - 1'b1]) begin
            if (!last) begin
              k_d     = k_q + 1'b1;
              ld      = 1'b1;
              ld_rd   = 1'b1;
              ld_addr = next_addr;
              state_d = PAT_RD;
            end else if (en_after_q) begin
              ld      = 1'b1;
              ld_addr = ADDR_WIDTH'(CTRL_ADDR);
              ld_data = REG_WIDTH'(CTRL_ENABLE);
              state_d = EN_WR;
            end else begin
              state_d = FIN;
            end
          end else begin
            err_d      = 1'b1;
            err_addr_d = cur_addr;
            state_d    = FIN;
          end
        end else if (tmr_q == TW'(1)) begin
          // Last cycle of the wait window with still no data.
          err_d      = 1'b1;
          err_addr_d = cur_addr;
          state_d    = FIN;
        end
      end

      EN_WR: begin
        if (acc) begin
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      k_q        <= '0;
      tmr_q      <= '0;
      pat_q      <= '{default: '0};
      en_after_q <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      tmr_q      <= tmr_d;
      pat_q      <= pat_d;
      en_after_q <= en_after_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == FIN);
  assign err_o      = (state_q == FIN) & err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader with a small reactive Avalon-MM slave model.
// Slave: optional fixed stall per access, corrupt data for one address, or no readdatavalid for one address.
// All DUT outputs sampled on the falling edge; cycle numbers are counted from the start-sampling edge.
module tb_pattern_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_i;
  logic        start_i;
  logic        enable_after_i;
  logic [31:0] pattern_i [3];
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [3:0]  err_addr_o;

  pattern_loader_if #(.ADDR_WIDTH(4), .REG_WIDTH(32)) amm ();

  pattern_loader #(
    .REG_WIDTH  (32),
    .ADDR_WIDTH (4),
    .PAT_WIDTH  (3),
    .TIMEOUT    (16)
  ) dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .start_i        (start_i),
    .pattern_i      (pattern_i),
    .enable_after_i (enable_after_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .err_addr_o     (err_addr_o),
    .amm            (amm)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Log entry: {cycle, is_read, addr, data}; read entries carry data 0.
  function automatic logic [63:0] op(input int c, input bit r, input int a, input logic [31:0] d);
    return {11'd0, 16'(c), r, 4'(a), d};
  endfunction

  // ---------------- slave model ----------------
  logic [31:0] mem [16];
  int          stall_n   = 0;
  int          bad_addr  = -1;
  int          drop_addr = -1;
  int          stall_cnt = 0;
  logic        rdv_q     = 1'b0;
  logic [31:0] rdat_q    = '0;
  int          pcount    = 0;
  int          base      = 0;
  int          stall_viol = 0;
  int          both_viol  = 0;
  logic        held_vld  = 1'b0;
  logic [37:0] held      = '0;
  logic [63:0] log_q [$];
  logic [63:0] exp_q [$];
  int          log_base  = 0;
  logic        cmd;
  logic [37:0] cur_cmd;

  assign cmd     = amm.amm_write_o | amm.amm_read_o;
  assign cur_cmd = {amm.amm_write_o, amm.amm_read_o, amm.amm_address_o, amm.amm_writedata_o};
  assign amm.amm_waitrequest_i   = cmd && (stall_cnt < stall_n);
  assign amm.amm_readdata_i      = rdat_q;
  assign amm.amm_readdatavalid_i = rdv_q;

  always @(posedge clk) begin
    pcount <= pcount + 1;
    rdv_q  <= 1'b0;
    if (amm.amm_write_o && amm.amm_read_o) both_viol <= both_viol + 1;
    if (held_vld && (cur_cmd != held)) stall_viol <= stall_viol + 1;
    if (cmd && amm.amm_waitrequest_i) begin
      stall_cnt <= stall_cnt + 1;
      held_vld  <= 1'b1;
      held      <= cur_cmd;
    end else begin
      held_vld <= 1'b0;
      if (cmd) begin
        stall_cnt <= 0;
        log_q.push_back(op(pcount - base, amm.amm_read_o, int'(amm.amm_address_o),
                           amm.amm_read_o ? 32'h0 : amm.amm_writedata_o));
        if (amm.amm_write_o) begin
          mem[amm.amm_address_o] <= amm.amm_writedata_o;
        end else begin
          rdv_q  <= (int'(amm.amm_address_o) != drop_addr);
          rdat_q <= (int'(amm.amm_address_o) == bad_addr) ? 32'hDEADBEEF : mem[amm.amm_address_o];
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic run_start(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2, input logic en);
    @(negedge clk);
    start_i        = 1'b1;
    pattern_i[0]   = p0;
    pattern_i[1]   = p1;
    pattern_i[2]   = p2;
    enable_after_i = en;
    log_base       = log_q.size();
    @(posedge clk);
    base = pcount;
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int rel, output logic e, output logic [3:0] ea);
    logic seen;
    seen = 1'b0;
    rel  = -1;
    e    = 1'b0;
    ea   = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        rel  = pcount - base;
        e    = err_o;
        ea   = err_addr_o;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nops"}, 64'(log_q.size() - log_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (log_base + i < log_q.size())
        chk($sformatf("%s_op%0d", tag, i), log_q[log_base + i], exp_q[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  int          rel;
  logic        e;
  logic [3:0]  ea;
  int          dones;

  initial begin
    srst_i         = 1'b1;
    start_i        = 1'b0;
    enable_after_i = 1'b0;
    pattern_i[0]   = '0;
    pattern_i[1]   = '0;
    pattern_i[2]   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     64'(busy_o),          64'd0);
    chk("rst_done",     64'(done_o),          64'd0);
    chk("rst_err",      64'(err_o),           64'd0);
    chk("rst_err_addr", 64'(err_addr_o),      64'd0);
    chk("rst_write",    64'(amm.amm_write_o), 64'd0);
    chk("rst_read",     64'(amm.amm_read_o),  64'd0);
    srst_i = 1'b0;

    // 1: zero-wait, enable after
    run_start(32'h11111111, 32'h22222222, 32'h33333333, 1'b1);
    wait_done("t1", 60, rel, e, ea);
    chk("t1_done_cyc", 64'(rel), 64'd12);
    chk("t1_err",      64'(e),   64'd0);
    exp_q.delete();
    exp_q.push_back(op(1, 0, 0, 32'h0));
    exp_q.push_back(op(2, 0, 1, 32'h11111111));
    exp_q.push_back(op(3, 0, 2, 32'h22222222));
    exp_q.push_back(op(4, 0, 3, 32'h33333333));
    exp_q.push_back(op(5, 1, 1, 32'h0));
    exp_q.push_back(op(7, 1, 2, 32'h0));
    exp_q.push_back(op(9, 1, 3, 32'h0));
    exp_q.push_back(op(11, 0, 0, 32'h1));
    check_log("t1");
    @(negedge clk);
    chk("t1_wrken",     64'(mem[0]), 64'd1);
    chk("t1_busy_after", 64'(busy_o), 64'd0);
    chk("t1_done_pulse", 64'(done_o), 64'd0);

    // 2: three stall cycles on every access
    stall_n = 3;
    run_start(32'h01020304, 32'h05060708, 32'h090A0B0C, 1'b1);
    wait_done("t2", 120, rel, e, ea);
    chk("t2_done_cyc", 64'(rel), 64'd36);
    chk("t2_err",      64'(e),   64'd0);
    exp_q.delete();
    exp_q.push_back(op(4,  0, 0, 32'h0));
    exp_q.push_back(op(8,  0, 1, 32'h01020304));
    exp_q.push_back(op(12, 0, 2, 32'h05060708));
    exp_q.push_back(op(16, 0, 3, 32'h090A0B0C));
    exp_q.push_back(op(20, 1, 1, 32'h0));
    exp_q.push_back(op(25, 1, 2, 32'h0));
    exp_q.push_back(op(30, 1, 3, 32'h0));
    exp_q.push_back(op(35, 0, 0, 32'h1));
    check_log("t2");
    chk("t2_stall_hold", 64'(stall_viol), 64'd0);
    stall_n = 0;

    // 3: corrupt read-back at address 2
    bad_addr = 2;
    run_start(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 1'b1);
    wait_done("t3", 60, rel, e, ea);
    chk("t3_done_cyc", 64'(rel), 64'd9);
    chk("t3_err",      64'(e),   64'd1);
    chk("t3_err_addr", 64'(ea),  64'd2);
    exp_q.delete();
    exp_q.push_back(op(1, 0, 0, 32'h0));
    exp_q.push_back(op(2, 0, 1, 32'hA5A5A5A5));
    exp_q.push_back(op(3, 0, 2, 32'h5A5A5A5A));
    exp_q.push_back(op(4, 0, 3, 32'h0F0F0F0F));
    exp_q.push_back(op(5, 1, 1, 32'h0));
    exp_q.push_back(op(7, 1, 2, 32'h0));
    check_log("t3");
    repeat (3) @(negedge clk);
    chk("t3_wrken",         64'(mem[0]),     64'd0);
    chk("t3_err_addr_hold", 64'(err_addr_o), 64'd2);
    chk("t3_err_idle",      64'(err_o),      64'd0);
    bad_addr = -1;

    // 4: no readdatavalid for address 1
    drop_addr = 1;
    run_start(32'hCAFEF00D, 32'h12345678, 32'h87654321, 1'b1);
    @(negedge clk);
    chk("t4_busy",           64'(busy_o),     64'd1);
    chk("t4_err_addr_clear", 64'(err_addr_o), 64'd0);
    wait_done("t4", 60, rel, e, ea);
    chk("t4_done_cyc", 64'(rel), 64'd22);
    chk("t4_err",      64'(e),   64'd1);
    chk("t4_err_addr", 64'(ea),  64'd1);
    chk("t4_nops",     64'(log_q.size() - log_base), 64'd5);
    @(negedge clk);
    chk("t4_busy_after", 64'(busy_o), 64'd0);
    chk("t4_wrken",      64'(mem[0]), 64'd0);
    drop_addr = -1;

    // 5: start during PAT_WR ignored, enable_after=0, then a fresh start is taken
    run_start(32'h00000AAA, 32'h00000BBB, 32'h00000CCC, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start_i        = 1'b1;
    pattern_i[0]   = 32'hFFFF0001;
    pattern_i[1]   = 32'hFFFF0002;
    pattern_i[2]   = 32'hFFFF0003;
    enable_after_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("t5", 60, rel, e, ea);
    chk("t5_done_cyc", 64'(rel), 64'd11);
    chk("t5_err",      64'(e),   64'd0);
    exp_q.delete();
    exp_q.push_back(op(1, 0, 0, 32'h0));
    exp_q.push_back(op(2, 0, 1, 32'h00000AAA));
    exp_q.push_back(op(3, 0, 2, 32'h00000BBB));
    exp_q.push_back(op(4, 0, 3, 32'h00000CCC));
    exp_q.push_back(op(5, 1, 1, 32'h0));
    exp_q.push_back(op(7, 1, 2, 32'h0));
    exp_q.push_back(op(9, 1, 3, 32'h0));
    check_log("t5");
    chk("t5_wrken", 64'(mem[0]), 64'd0);
    run_start(32'h13579BDF, 32'h2468ACE0, 32'h0BADF00D, 1'b1);
    wait_done("t5b", 60, rel, e, ea);
    chk("t5b_done_cyc", 64'(rel), 64'd12);
    @(negedge clk);
    chk("t5b_mem1",  64'(mem[1]), 64'h13579BDF);
    chk("t5b_mem2",  64'(mem[2]), 64'h2468ACE0);
    chk("t5b_mem3",  64'(mem[3]), 64'h0BADF00D);
    chk("t5b_wrken", 64'(mem[0]), 64'd1);

    // 6: reset while waiting for read data, then a clean run
    drop_addr = 1;
    run_start(32'h44444444, 32'h55555555, 32'h66666666, 1'b1);
    repeat (8) @(negedge clk);
    chk("t6_busy_wait", 64'(busy_o), 64'd1);
    srst_i = 1'b1;
    @(negedge clk);
    srst_i = 1'b0;
    chk("t6_write_rst", 64'(amm.amm_write_o), 64'd0);
    chk("t6_read_rst",  64'(amm.amm_read_o),  64'd0);
    chk("t6_busy_rst",  64'(busy_o),          64'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    chk("t6_no_done", 64'(dones), 64'd0);
    drop_addr = -1;
    run_start(32'h77777777, 32'h88888888, 32'h99999999, 1'b1);
    wait_done("t6b", 60, rel, e, ea);
    chk("t6b_done_cyc", 64'(rel), 64'd12);
    chk("t6b_err",      64'(e),   64'd0);
    exp_q.delete();
    exp_q.push_back(op(1, 0, 0, 32'h0));
    exp_q.push_back(op(2, 0, 1, 32'h77777777));
    exp_q.push_back(op(3, 0, 2, 32'h88888888));
    exp_q.push_back(op(4, 0, 3, 32'h99999999));
    exp_q.push_back(op(5, 1, 1, 32'h0));
    exp_q.push_back(op(7, 1, 2, 32'h0));
    exp_q.push_back(op(9, 1, 3, 32'h0));
    exp_q.push_back(op(11, 0, 0, 32'h1));
    check_log("t6b");

    chk("rd_wr_exclusive", 64'(both_viol),  64'd0);
    chk("stall_hold_all",  64'(stall_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
